spi_rr_arbiter: RTL and testbench
=================================

# spi_rr_arbiter

Round-robin arbiter that shares the single SPI-adapter val/rdy message channel of the tapein top among NREQ on-chip requesters, e.g. the async-FIFO path, classifier configuration and debug readback. Each outgoing message is tagged with the requester index. Responses returning on the adapter's receive channel are routed back to the requester named by their tag. A per-requester outstanding-transaction counter bounds in-flight traffic so that no requester can starve the channel or overflow its response path.

## Interface
- NREQ, 4, number of requesters (2..8)
- MSG_W, 20, payload width per requester
- MAX_OUT, 2, max outstanding (sent, unanswered) messages per requester (1..7)
- TAG_W, derived = clog2(NREQ), tag width (not user-set)

- clk  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-low reset
- req_msg  in  NREQ*MSG_W  requester payloads, lane i = bits [i*MSG_W +: MSG_W]
- req_val  in  NREQ  requester valid
- req_rdy  out  NREQ  requester ready
- send_msg  out  TAG_W+MSG_W  {tag, payload} to SPI adapter
- send_val  out  1  send valid
- send_rdy  in  1  adapter ready
- recv_msg  in  TAG_W+MSG_W  {tag, payload} response from adapter
- recv_val  in  1  response valid
- recv_rdy  out  1  response ready
- resp_msg  out  MSG_W  response payload, broadcast to all lanes
- resp_val  out  NREQ  per-requester response valid
- resp_rdy  in  NREQ  per-requester response ready
- err_unexp  out  1  sticky: response with invalid tag or no outstanding entry

## Operation
- FSM states:
  - IDLE: no message held.
  - HOLD: send register full, send_val=1.
- Eligibility: requester i is eligible when req_val[i]=1 and out_cnt[i] < MAX_OUT.
- IDLE behaviour:
  - Grant the first eligible index, searching ptr, ptr+1, ... modulo NREQ.
  - req_rdy is one-hot on the granted index, driven combinationally. It is all-zero when no requester is eligible or the state is HOLD.
- Accept (req_val[g] & req_rdy[g]):
  - Load the send register with {g, req_msg lane g}.
  - ptr <= (g+1) mod NREQ.
  - Next state HOLD.
- HOLD behaviour:
  - send_msg is stable and send_val=1 until send_rdy.
  - On send fire: out_cnt[tag]++ and next state IDLE.
  - req_rdy stays 0 during the fire cycle.
- Response routing:
  - resp_val[i] = recv_val & (recv tag == i) & tag valid & out_cnt[i] != 0.
  - recv_rdy = resp_rdy[tag] for a valid response.
  - resp_msg = recv payload.
- Response fire (recv_val & recv_rdy, valid): out_cnt[tag]--.
- Invalid response (tag >= NREQ or out_cnt[tag]==0):
  - recv_rdy=1, so the response is dropped in one cycle.
  - No resp_val is asserted.
  - err_unexp <= 1, held until reset.
- Counter update: if increment and decrement hit the same out_cnt in one cycle, it is unchanged. Counters never wrap: eligibility blocks the increment at MAX_OUT, and an invalid response blocks the decrement at 0.
- Reset mid-operation: any held message is discarded (not sent) and all counters clear. Responses that arrive after reset for pre-reset messages are flagged err_unexp.

## Timing
- Reset values:
  - state IDLE, ptr 0, out_cnt all 0, err_unexp 0
  - send_val 0, send_msg 0
  - resp_val, req_rdy and recv_rdy follow combinationally from the cleared state.
- Latency: request accepted at edge N gives send_val=1 from cycle N+1.
- Minimum spacing between successive sends is 2 cycles (one send per HOLD→IDLE→HOLD round trip).
- Response path is combinational; it adds 0 cycles.
- Request and response paths run in the same cycle independently. The eligibility check uses registered out_cnt (pre-update values).
- Arbitration fairness: with k requesters continuously eligible, each is granted exactly once per k grants.

## Test plan
- Single send:
  - Stimulus: NREQ=4; req_val[2]=1, msg 0x0ABCD; send_rdy=1.
  - Required: req_rdy=0b0100 in cycle 0; send_val=1 with send_msg={2'd2, 0x0ABCD} in cycle 1; IDLE in cycle 2; out_cnt[2]=1.
- Round-robin:
  - Stimulus: all four req_val held 1; responses returned promptly; send_rdy=1.
  - Required: grant order 0,1,2,3,0,1; send tags match that order.
- Backpressure:
  - Stimulus: send_rdy=0 for 5 cycles after accept.
  - Required: send_msg stable and send_val=1 throughout; req_rdy=0; exactly one send on release.
- Outstanding limit:
  - Stimulus: MAX_OUT=2; requester 1 sends twice with no response, then requests a third time.
  - Required: req_rdy[1] stays 0 and other requesters are still granted. After one tag-1 response (resp_val[1]=1, resp_rdy[1]=1), requester 1 is granted again.
- Unexpected and simultaneous response:
  - Stimulus: a tag-3 response while out_cnt[3]=0.
  - Required: recv_rdy=1, resp_val=0, err_unexp=1 and held.
  - Stimulus: a tag-0 send fire and a tag-0 response fire in the same cycle.
  - Required: out_cnt[0] unchanged.
- Reset mid-HOLD:
  - Stimulus: assert reset while send_val=1 and send_rdy=0.
  - Required: send_val drops immediately (asynchronous); after release, out_cnt all 0, ptr 0, err_unexp 0, and the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter multiplexing NREQ requesters onto one tagged val/rdy send
// channel, with tag-routed responses and per-requester outstanding-message limits.
module spi_rr_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int MSG_W   = 20,
  parameter  int MAX_OUT = 2,
  localparam int TAG_W   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ*MSG_W-1:0]   req_msg,
  input  logic [NREQ-1:0]         req_val,
  output logic [NREQ-1:0]         req_rdy,
  output logic [TAG_W+MSG_W-1:0]  send_msg,
  output logic                    send_val,
  input  logic                    send_rdy,
  input  logic [TAG_W+MSG_W-1:0]  recv_msg,
  input  logic                    recv_val,
  output logic                    recv_rdy,
  output logic [MSG_W-1:0]        resp_msg,
  output logic [NREQ-1:0]         resp_val,
  input  logic [NREQ-1:0]         resp_rdy,
  output logic                    err_unexp
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [TAG_W:0]   NREQ_EXT = (TAG_W+1)'(NREQ);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  logic [TAG_W-1:0] ptr;
  logic [CNT_W-1:0] out_cnt [NREQ];

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  route_hit;
  logic [NREQ-1:0]  cnt_inc;
  logic [NREQ-1:0]  cnt_dec;
  logic             grant_found;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W-1:0] cand;
  logic [TAG_W:0]   cand_sum;
  logic [TAG_W-1:0] send_tag;
  logic [TAG_W-1:0] recv_tag;
  logic             accept;
  logic             send_fire;
  logic             unexp;

  assign send_val  = (state == HOLD);
  assign send_fire = send_val && send_rdy;
  assign send_tag  = send_msg[MSG_W +: TAG_W];
  assign recv_tag  = recv_msg[MSG_W +: TAG_W];
  assign resp_msg  = recv_msg[MSG_W-1:0];

  // A tag matching no lane, or a lane with nothing in flight, leaves route_hit empty.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      eligible[i]  = req_val[i] && (out_cnt[i] < MAX_CNT);
      route_hit[i] = (recv_tag == TAG_W'(i)) && (out_cnt[i] != '0);
      cnt_inc[i]   = send_fire && (send_tag == TAG_W'(i));
      cnt_dec[i]   = recv_val && route_hit[i] && resp_rdy[i];
    end
  end

  assign resp_val = {NREQ{recv_val}} & route_hit;
  assign recv_rdy = (|route_hit) ? |(route_hit & resp_rdy) : 1'b1;
  assign unexp    = recv_val && !(|route_hit);

  // Rotating search starting at ptr; the sum never exceeds 2*NREQ-2, so one
  // conditional subtraction implements the modulo.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, ptr} + (TAG_W+1)'(k);
      if (cand_sum >= NREQ_EXT) cand_sum = cand_sum - NREQ_EXT;
      cand = cand_sum[TAG_W-1:0];
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept = (state == IDLE) && grant_found;

  always_comb begin
    req_rdy = '0;
    if (accept) req_rdy[grant_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      send_msg  <= '0;
      err_unexp <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          send_msg <= {grant_idx, req_msg[grant_idx*MSG_W +: MSG_W]};
          ptr      <= (grant_idx == TAG_W'(NREQ - 1)) ? '0 : grant_idx + TAG_W'(1);
          state    <= HOLD;
        end
        HOLD: if (send_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (unexp) err_unexp <= 1'b1;
    end
  end

  // Simultaneous send and response on one lane cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      out_cnt[i] <= out_cnt[i] + CNT_W'(1);
        else if (cnt_dec[i] && !cnt_inc[i]) out_cnt[i] <= out_cnt[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// Directed bench for spi_rr_arbiter: one task per scenario, inline comparisons
// against hand-computed values, single summary line at the end.
module tb_spi_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int MSG_W   = 20;
  localparam int MAX_OUT = 2;
  localparam int TAG_W   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ*MSG_W-1:0]  req_msg;
  logic [NREQ-1:0]        req_val;
  logic [NREQ-1:0]        req_rdy;
  logic [TAG_W+MSG_W-1:0] send_msg;
  logic                   send_val;
  logic                   send_rdy;
  logic [TAG_W+MSG_W-1:0] recv_msg;
  logic                   recv_val;
  logic                   recv_rdy;
  logic [MSG_W-1:0]       resp_msg;
  logic [NREQ-1:0]        resp_val;
  logic [NREQ-1:0]        resp_rdy;
  logic                   err_unexp;

  int checks   = 0;
  int failures = 0;

  spi_rr_arbiter #(.NREQ(NREQ), .MSG_W(MSG_W), .MAX_OUT(MAX_OUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_msg  (req_msg),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .resp_msg (resp_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Advance one cycle; inputs are driven and outputs sampled mid-low-phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_msg  = '0;
    req_val  = '0;
    send_rdy = 1'b0;
    recv_msg = '0;
    recv_val = 1'b0;
    resp_rdy = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    #1;
    checks++;
    if (send_val !== 1'b0) begin failures++; $display("FAIL reset_send_val got=%b exp=0", send_val); end
    checks++;
    if (send_msg !== '0) begin failures++; $display("FAIL reset_send_msg got=%h exp=0", send_msg); end
    checks++;
    if (req_rdy !== 4'b0000) begin failures++; $display("FAIL reset_req_rdy got=%b exp=0000", req_rdy); end
    checks++;
    if (resp_val !== 4'b0000) begin failures++; $display("FAIL reset_resp_val got=%b exp=0000", resp_val); end
    checks++;
    if (recv_rdy !== 1'b1) begin failures++; $display("FAIL reset_recv_rdy got=%b exp=1", recv_rdy); end
    checks++;
    if (err_unexp !== 1'b0) begin failures++; $display("FAIL reset_err_unexp got=%b exp=0", err_unexp); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single_send();
    req_val = 4'b0100;
    req_msg[2*MSG_W +: MSG_W] = 20'h0ABCD;
    send_rdy = 1'b1;
    #1;
    checks++;
    if (req_rdy !== 4'b0100) begin failures++; $display("FAIL single_req_rdy got=%b exp=0100", req_rdy); end
    tick();
    req_val = '0;
    #1;
    checks++;
    if (send_val !== 1'b1 || send_msg !== {2'd2, 20'h0ABCD})
      begin failures++; $display("FAIL single_send got=%b/%h exp=1/%h", send_val, send_msg, {2'd2, 20'h0ABCD}); end
    checks++;
    if (req_rdy !== 4'b0000) begin failures++; $display("FAIL single_hold_req_rdy got=%b exp=0000", req_rdy); end
    tick();
    #1;
    checks++;
    if (send_val !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", send_val); end
    checks++;
    if (dut.out_cnt[2] !== 2'd1) begin failures++; $display("FAIL single_out_cnt got=%0d exp=1", dut.out_cnt[2]); end
    recv_val = 1'b1;
    recv_msg = {2'd2, 20'h12345};
    resp_rdy = 4'b0100;
    #1;
    checks++;
    if (resp_val !== 4'b0100 || resp_msg !== 20'h12345 || recv_rdy !== 1'b1)
      begin failures++; $display("FAIL single_resp got=%b/%h/%b exp=0100/12345/1", resp_val, resp_msg, recv_rdy); end
    tick();
    recv_val = 1'b0;
    #1;
    checks++;
    if (dut.out_cnt[2] !== 2'd0) begin failures++; $display("FAIL single_out_cnt_ret got=%0d exp=0", dut.out_cnt[2]); end
  endtask

  task automatic test_round_robin();
    logic [TAG_W-1:0] prev_tag;
    logic [TAG_W-1:0] t;
    logic [NREQ-1:0]  exp_rdy;
    do_reset();
    for (int i = 0; i < NREQ; i++) req_msg[i*MSG_W +: MSG_W] = 20'h10000 + 20'(i);
    req_val  = 4'b1111;
    send_rdy = 1'b1;
    resp_rdy = 4'b1111;
    prev_tag = '0;
    for (int k = 0; k < 6; k++) begin
      t = 2'(k % 4);
      if (k > 0) begin
        recv_val = 1'b1;
        recv_msg = {prev_tag, 20'h00F00};
      end
      #1;
      exp_rdy = 4'b0001 << t;
      checks++;
      if (req_rdy !== exp_rdy) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_rdy, exp_rdy); end
      tick();
      recv_val = 1'b0;
      #1;
      checks++;
      if (send_val !== 1'b1 || send_msg !== {t, 20'h10000 + 20'(t)})
        begin failures++; $display("FAIL rr_send%0d got=%b/%h exp=1/%h", k, send_val, send_msg, {t, 20'h10000 + 20'(t)}); end
      tick();
      prev_tag = t;
    end
    req_val = '0;
    recv_val = 1'b1;
    recv_msg = {prev_tag, 20'h00F00};
    tick();
    recv_val = 1'b0;
    #1;
    checks++;
    if (err_unexp !== 1'b0) begin failures++; $display("FAIL rr_err_unexp got=%b exp=0", err_unexp); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_val = 4'b0001;
    req_msg[0 +: MSG_W] = 20'h0BEEF;
    send_rdy = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (send_val !== 1'b1 || send_msg !== {2'd0, 20'h0BEEF} || req_rdy !== 4'b0000)
        begin failures++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/%h/0000", c, send_val, send_msg, req_rdy, {2'd0, 20'h0BEEF}); end
      tick();
    end
    send_rdy = 1'b1;
    req_val  = '0;
    #1;
    checks++;
    if (req_rdy !== 4'b0000) begin failures++; $display("FAIL bp_fire_req_rdy got=%b exp=0000", req_rdy); end
    tick();
    tick();
    #1;
    checks++;
    if (send_val !== 1'b0 || dut.out_cnt[0] !== 2'd1)
      begin failures++; $display("FAIL bp_one_send got=%b/%0d exp=0/1", send_val, dut.out_cnt[0]); end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    send_rdy = 1'b1;
    req_val  = 4'b0010;
    req_msg[1*MSG_W +: MSG_W] = 20'h00011;
    req_msg[2*MSG_W +: MSG_W] = 20'h00022;
    for (int s = 0; s < 2; s++) begin
      #1;
      checks++;
      if (req_rdy !== 4'b0010) begin failures++; $display("FAIL lim_send%0d got=%b exp=0010", s, req_rdy); end
      tick();
      tick();
    end
    #1;
    checks++;
    if (req_rdy !== 4'b0000) begin failures++; $display("FAIL lim_blocked got=%b exp=0000", req_rdy); end
    req_val = 4'b0110;
    #1;
    checks++;
    if (req_rdy !== 4'b0100) begin failures++; $display("FAIL lim_other got=%b exp=0100", req_rdy); end
    tick();
    req_val = 4'b0010;
    tick();
    recv_val = 1'b1;
    recv_msg = {2'd1, 20'h0AAAA};
    resp_rdy = 4'b0010;
    #1;
    checks++;
    if (resp_val !== 4'b0010 || recv_rdy !== 1'b1 || req_rdy !== 4'b0000)
      begin failures++; $display("FAIL lim_resp got=%b/%b/%b exp=0010/1/0000", resp_val, recv_rdy, req_rdy); end
    tick();
    recv_val = 1'b0;
    #1;
    checks++;
    if (req_rdy !== 4'b0010) begin failures++; $display("FAIL lim_regrant got=%b exp=0010", req_rdy); end
    req_val = '0;
    tick();
  endtask

  task automatic test_unexpected_and_simul();
    do_reset();
    recv_val = 1'b1;
    recv_msg = {2'd3, 20'h0DEAD};
    resp_rdy = '0;
    #1;
    checks++;
    if (recv_rdy !== 1'b1 || resp_val !== 4'b0000 || err_unexp !== 1'b0)
      begin failures++; $display("FAIL unexp_comb got=%b/%b/%b exp=1/0000/0", recv_rdy, resp_val, err_unexp); end
    tick();
    recv_val = 1'b0;
    #1;
    checks++;
    if (err_unexp !== 1'b1) begin failures++; $display("FAIL unexp_set got=%b exp=1", err_unexp); end
    // Build out_cnt[0]=1, then hold a second tag-0 message.
    send_rdy = 1'b1;
    req_val  = 4'b0001;
    req_msg[0 +: MSG_W] = 20'h00005;
    tick();
    tick();
    tick();
    req_val  = '0;
    recv_val = 1'b1;
    recv_msg = {2'd0, 20'h00055};
    resp_rdy = 4'b0001;
    #1;
    checks++;
    if (send_val !== 1'b1 || resp_val !== 4'b0001)
      begin failures++; $display("FAIL simul_setup got=%b/%b exp=1/0001", send_val, resp_val); end
    tick();
    recv_val = 1'b0;
    #1;
    checks++;
    if (dut.out_cnt[0] !== 2'd1 || send_val !== 1'b0)
      begin failures++; $display("FAIL simul_cnt got=%0d/%b exp=1/0", dut.out_cnt[0], send_val); end
    checks++;
    if (err_unexp !== 1'b1) begin failures++; $display("FAIL unexp_held got=%b exp=1", err_unexp); end
  endtask

  task automatic test_reset_mid_hold();
    logic cnt_bad;
    req_val  = 4'b0100;
    req_msg[2*MSG_W +: MSG_W] = 20'h0C0DE;
    send_rdy = 1'b0;
    tick();
    #1;
    checks++;
    if (send_val !== 1'b1) begin failures++; $display("FAIL mid_hold_setup got=%b exp=1", send_val); end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (send_val !== 1'b0 || send_msg !== '0 || err_unexp !== 1'b0)
      begin failures++; $display("FAIL mid_async got=%b/%h/%b exp=0/0/0", send_val, send_msg, err_unexp); end
    clear_inputs();
    tick();
    reset = 1'b1;
    #1;
    cnt_bad = 1'b0;
    for (int i = 0; i < NREQ; i++) if (dut.out_cnt[i] !== 2'd0) cnt_bad = 1'b1;
    checks++;
    if (cnt_bad !== 1'b0 || dut.ptr !== 2'd0)
      begin failures++; $display("FAIL mid_cleared got=%b/%0d exp=0/0", cnt_bad, dut.ptr); end
    req_val = 4'b1010;
    #1;
    checks++;
    if (req_rdy !== 4'b0010) begin failures++; $display("FAIL mid_first_grant got=%b exp=0010", req_rdy); end
    req_val  = '0;
    recv_val = 1'b1;
    recv_msg = {2'd2, 20'h0C0DE};
    resp_rdy = 4'b1111;
    tick();
    recv_val = 1'b0;
    #1;
    checks++;
    if (err_unexp !== 1'b1) begin failures++; $display("FAIL mid_stale_resp got=%b exp=1", err_unexp); end
  endtask

  initial begin
    test_reset();
    test_single_send();
    test_round_robin();
    test_backpressure();
    test_outstanding_limit();
    test_unexpected_and_simul();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
